// File: rtl/game_pkg.sv
// Shared definitions for the tug-of-war game datapath: arbiter state
// encoding, winner codes and default lockout sizing.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_Q  = 3'd1,
    ST_WAIT_Q = 3'd2,
    ST_ARMED  = 3'd3,
    ST_MOVE   = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned LOCKOUT_TICKS_DEFAULT = 30;
  localparam int unsigned CNT_W_DEFAULT         = 8;

  // Exact tie: token 0 favours P1, token 1 favours P2.
  function automatic logic [1:0] tie_winner(input logic token);
    return token ? WIN_P2 : WIN_P1;
  endfunction

endpackage

// File: rtl/submit_arbiter_if.sv
// Player-submit / question-select / rope-move bundle around submit_arbiter.
interface submit_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             game_tick;
  logic             round_enable;
  logic             p1_submit;
  logic             p2_submit;
  logic [3:0]       p1_answer;
  logic [3:0]       p2_answer;
  logic [3:0]       correct_ans;
  logic             question_ready;
  logic             move_left;
  logic             move_right;
  logic             q_request;
  logic             p1_locked;
  logic             p2_locked;
  logic [1:0]       last_winner;
  logic [CNT_W-1:0] round_count;

  modport slave (
    input  game_tick, round_enable, p1_submit, p2_submit, p1_answer, p2_answer,
           correct_ans, question_ready,
    output move_left, move_right, q_request, p1_locked, p2_locked,
           last_winner, round_count
  );

  modport master (
    output game_tick, round_enable, p1_submit, p2_submit, p1_answer, p2_answer,
           correct_ans, question_ready,
    input  move_left, move_right, q_request, p1_locked, p2_locked,
           last_winner, round_count
  );

endinterface

// File: rtl/lockout_timer.sv
// Per-player wrong-answer lockout: loads LOCKOUT_TICKS on a miss and counts
// down on game_tick; locked while the count is nonzero.
module lockout_timer
  import game_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEFAULT,
  parameter int unsigned LOCKOUT_TICKS = LOCKOUT_TICKS_DEFAULT
) (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic locked
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(LOCKOUT_TICKS);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign locked = (cnt_q != '0);

endmodule

// File: rtl/submit_arbiter.sv
// Arbitrates P1/P2 answer submissions per question, sequences the question
// request handshake and issues one rope-move pulse per won question.
module submit_arbiter
  import game_pkg::*;
#(
  parameter int unsigned LOCKOUT_TICKS = LOCKOUT_TICKS_DEFAULT,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  submit_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic             move_left_q, move_left_d;
  logic             move_right_q, move_right_d;
  logic             q_request_q, q_request_d;
  logic [1:0]       last_winner_q, last_winner_d;
  logic [CNT_W-1:0] round_count_q, round_count_d;
  logic             tie_token_q, tie_token_d;

  logic       p1_locked, p2_locked;
  logic       p1_load, p2_load;
  logic       clear_locks;
  logic       p1_hit, p1_miss, p2_hit, p2_miss;
  logic [1:0] win;

  always_comb begin
    p1_hit  = bus.p1_submit && !p1_locked && (bus.p1_answer == bus.correct_ans);
    p1_miss = bus.p1_submit && !p1_locked && (bus.p1_answer != bus.correct_ans);
    p2_hit  = bus.p2_submit && !p2_locked && (bus.p2_answer == bus.correct_ans);
    p2_miss = bus.p2_submit && !p2_locked && (bus.p2_answer != bus.correct_ans);
  end

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    round_count_d = round_count_q;
    tie_token_d   = tie_token_q;
    p1_load       = 1'b0;
    p2_load       = 1'b0;
    win           = WIN_NONE;

    unique case (state_q)
      ST_IDLE:   if (bus.round_enable) state_d = ST_REQ_Q;
      ST_REQ_Q:  state_d = ST_WAIT_Q;
      ST_WAIT_Q: if (bus.question_ready) state_d = ST_ARMED;
      ST_ARMED: begin
        if (p1_hit && p2_hit) begin
          win         = tie_winner(tie_token_q);
          tie_token_d = ~tie_token_q;
        end else if (p1_hit) begin
          win     = WIN_P1;
          p2_load = p2_miss;
        end else if (p2_hit) begin
          win     = WIN_P2;
          p1_load = p1_miss;
        end else begin
          p1_load = p1_miss;
          p2_load = p2_miss;
        end
        if (win != WIN_NONE) begin
          state_d       = ST_MOVE;
          last_winner_d = win;
          round_count_d = (&round_count_q) ? round_count_q : round_count_q + 1'b1;
        end
      end
      ST_MOVE:   state_d = ST_REQ_Q;
      default:   state_d = ST_IDLE;
    endcase

    // Dropping round_enable aborts from any state and squashes pending pulses.
    if (!bus.round_enable) begin
      state_d = ST_IDLE;
    end
    if (state_d == ST_IDLE) begin
      last_winner_d = WIN_NONE;
      round_count_d = '0;
      tie_token_d   = 1'b0;
      win           = WIN_NONE;
      p1_load       = 1'b0;
      p2_load       = 1'b0;
    end

    clear_locks  = (state_d == ST_IDLE);
    // Outputs are registered from the next state so each pulse lines up with
    // the cycle the FSM spends in MOVE / REQ_Q.
    move_left_d  = (win == WIN_P1);
    move_right_d = (win == WIN_P2);
    q_request_d  = (state_d == ST_REQ_Q);
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      move_left_q   <= 1'b0;
      move_right_q  <= 1'b0;
      q_request_q   <= 1'b0;
      last_winner_q <= WIN_NONE;
      round_count_q <= '0;
      tie_token_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      move_left_q   <= move_left_d;
      move_right_q  <= move_right_d;
      q_request_q   <= q_request_d;
      last_winner_q <= last_winner_d;
      round_count_q <= round_count_d;
      tie_token_q   <= tie_token_d;
    end
  end

  lockout_timer #(
    .CNT_W         (CNT_W),
    .LOCKOUT_TICKS (LOCKOUT_TICKS)
  ) u_p1_lock (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .clear      (clear_locks),
    .load       (p1_load),
    .tick       (bus.game_tick),
    .locked     (p1_locked)
  );

  lockout_timer #(
    .CNT_W         (CNT_W),
    .LOCKOUT_TICKS (LOCKOUT_TICKS)
  ) u_p2_lock (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .clear      (clear_locks),
    .load       (p2_load),
    .tick       (bus.game_tick),
    .locked     (p2_locked)
  );

  assign bus.move_left   = move_left_q;
  assign bus.move_right  = move_right_q;
  assign bus.q_request   = q_request_q;
  assign bus.p1_locked   = p1_locked;
  assign bus.p2_locked   = p2_locked;
  assign bus.last_winner = last_winner_q;
  assign bus.round_count = round_count_q;

endmodule

// File: tb/tb_submit_arbiter.sv
// Directed bench for submit_arbiter: expected move/q_request pulses are queued
// at stimulus time and matched cycle-exactly as the DUT emits them.
module tb_submit_arbiter;
  import game_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ml;
    logic        mr;
    logic        qr;
    logic [1:0]  lw;
    logic [7:0]  rc;
  } ev_t;

  logic        clk_100mhz;
  logic        reset;
  logic [31:0] cyc;
  int          n_cmp;
  int          n_fail;
  ev_t         sb[$];
  logic [1:0]  exp_lw;
  logic [7:0]  exp_rc;

  submit_arbiter_if #(.CNT_W(8)) bus ();

  submit_arbiter #(
    .LOCKOUT_TICKS (30),
    .CNT_W         (8)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (bus)
  );

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  initial cyc = '0;
  always @(posedge clk_100mhz) cyc <= cyc + 32'd1;

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic step_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic ml, input logic mr, input logic qr);
    ev_t e;
    e.cyc = c;
    e.ml  = ml;
    e.mr  = mr;
    e.qr  = qr;
    e.lw  = exp_lw;
    e.rc  = exp_rc;
    sb.push_back(e);
  endtask

  task automatic submit(input logic s1, input logic [3:0] a1,
                        input logic s2, input logic [3:0] a2);
    bus.p1_submit = s1;
    bus.p1_answer = a1;
    bus.p2_submit = s2;
    bus.p2_answer = a2;
    step();
    bus.p1_submit = 1'b0;
    bus.p2_submit = 1'b0;
  endtask

  // Winning submit in an ARMED cycle; returns in the next ARMED cycle.
  task automatic hit_round(input logic s1, input logic [3:0] a1,
                           input logic s2, input logic [3:0] a2,
                           input logic [1:0] w);
    logic [31:0] n;
    n = cyc;
    exp_lw = w;
    if (exp_rc != 8'hff) exp_rc = exp_rc + 8'd1;
    push(n + 32'd1, w == WIN_P1, w == WIN_P2, 1'b0);
    push(n + 32'd2, 1'b0, 1'b0, 1'b1);
    submit(s1, a1, s2, a2);
    step_n(3);
  endtask

  // Pulse monitor: every move/q_request pulse must match the scoreboard head.
  always @(negedge clk_100mhz) begin
    if (bus.move_left || bus.move_right || bus.q_request) begin
      ev_t o;
      ev_t e;
      o.cyc = cyc;
      o.ml  = bus.move_left;
      o.mr  = bus.move_right;
      o.qr  = bus.q_request;
      o.lw  = bus.last_winner;
      o.rc  = bus.round_count;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed cyc=%0d ml=%0b mr=%0b qr=%0b expected no pulse",
               cyc, o.ml, o.mr, o.qr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (o === e) else begin
          n_fail++;
          $error("FAIL sb_event: observed %0h expected %0h", o, e);
        end
      end
    end
  end

  // 60 Hz stand-in: one game_tick every 4 clocks.
  initial begin
    bus.game_tick = 1'b0;
    forever begin
      step_n(3);
      bus.game_tick = 1'b1;
      step();
      bus.game_tick = 1'b0;
    end
  end

  initial begin
    logic [31:0] n;
    n_cmp  = 0;
    n_fail = 0;
    exp_lw = WIN_NONE;
    exp_rc = 8'd0;
    reset              = 1'b1;
    bus.round_enable   = 1'b0;
    bus.p1_submit      = 1'b0;
    bus.p2_submit      = 1'b0;
    bus.p1_answer      = 4'd0;
    bus.p2_answer      = 4'd0;
    bus.correct_ans    = 4'd0;
    bus.question_ready = 1'b0;

    step_n(3);
    chk("reset_outputs", 32'({bus.move_left, bus.move_right, bus.q_request, bus.p1_locked,
                              bus.p2_locked, bus.last_winner, bus.round_count}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_outputs", 32'({bus.move_left, bus.move_right, bus.q_request, bus.p1_locked,
                             bus.p2_locked, bus.last_winner, bus.round_count}), 32'd0);

    // Single correct answer; a submit in WAIT_Q (ready already high) is ignored.
    bus.correct_ans    = 4'd5;
    bus.question_ready = 1'b1;
    bus.round_enable   = 1'b1;
    n = cyc;
    push(n + 32'd1, 1'b0, 1'b0, 1'b1);
    step_n(2);
    submit(1'b1, 4'd5, 1'b0, 4'd0);
    hit_round(1'b1, 4'd5, 1'b0, 4'd0, WIN_P1);

    // Wrong then right: lockout holds ~30 ticks and is not extended.
    n = cyc;
    submit(1'b0, 4'd0, 1'b1, 4'd3);
    chk("p2_lock_set", 32'(bus.p2_locked), 32'd1);
    chk("p1_not_locked", 32'(bus.p1_locked), 32'd0);
    step_n(39);
    submit(1'b0, 4'd0, 1'b1, 4'd5);
    step_n(68);
    chk("p2_lock_hold", 32'(bus.p2_locked), 32'd1);
    hit_round(1'b1, 4'd5, 1'b0, 4'd0, WIN_P1);
    step_n(16);
    chk("p2_lock_expire", 32'(bus.p2_locked), 32'd0);
    chk("rc_after_two", 32'(bus.round_count), 32'd2);

    // Exact ties on consecutive questions alternate the winner.
    hit_round(1'b1, 4'd5, 1'b1, 4'd5, WIN_P1);
    chk("tie1_locks", 32'({bus.p1_locked, bus.p2_locked}), 32'd0);
    hit_round(1'b1, 4'd5, 1'b1, 4'd5, WIN_P2);
    chk("tie2_locks", 32'({bus.p1_locked, bus.p2_locked}), 32'd0);

    // Hit plus miss in the same cycle.
    hit_round(1'b1, 4'd5, 1'b1, 4'd7, WIN_P1);
    chk("hitmiss_p2_locked", 32'(bus.p2_locked), 32'd1);
    chk("hitmiss_p1_free", 32'(bus.p1_locked), 32'd0);

    // Abort during MOVE: no q_request, everything cleared.
    n = cyc;
    exp_lw = WIN_P1;
    exp_rc = exp_rc + 8'd1;
    push(n + 32'd1, 1'b1, 1'b0, 1'b0);
    bus.p1_submit = 1'b1;
    bus.p1_answer = 4'd5;
    step();
    bus.p1_submit    = 1'b0;
    bus.round_enable = 1'b0;
    exp_lw = WIN_NONE;
    exp_rc = 8'd0;
    step();
    chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("abort_rc", 32'(bus.round_count), 32'd0);
    chk("abort_lw", 32'(bus.last_winner), 32'd0);
    chk("abort_locks", 32'({bus.p1_locked, bus.p2_locked}), 32'd0);
    step_n(4);

    // Question handshake: ready held low, submits ignored meanwhile.
    bus.question_ready = 1'b0;
    bus.round_enable   = 1'b1;
    n = cyc;
    push(n + 32'd1, 1'b0, 1'b0, 1'b1);
    step_n(50);
    submit(1'b1, 4'd3, 1'b1, 4'd3);
    chk("waitq_no_lock", 32'({bus.p1_locked, bus.p2_locked}), 32'd0);
    submit(1'b1, 4'd5, 1'b0, 4'd0);
    step_n(49);
    bus.question_ready = 1'b1;
    step();
    hit_round(1'b0, 4'd0, 1'b1, 4'd5, WIN_P2);
    chk("hs_rc", 32'(bus.round_count), 32'd1);
    chk("hs_lw", 32'(bus.last_winner), 32'(WIN_P2));
    step();
    bus.round_enable = 1'b0;
    step_n(4);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
